// File: rtl/ota_out_decimator.sv
// Sampling front end for the digital OTA comparator: synchronize, debounce, then
// report ones-density and level-toggle counts per 2^WIN_LOG2-sample window.
module ota_out_decimator #(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_LOG2    = 8,
  parameter int DEB_LEN     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ota_in,
  output logic [WIN_LOG2-1:0] density,
  output logic [7:0]          edges,
  output logic                density_valid,
  input  logic                density_ready,
  output logic                level,
  output logic                overrun,
  input  logic                clr_ovr
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0]          DEB_LAST = 4'(DEB_LEN - 1);
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = WIN_LOG2'(1);
  localparam logic [WIN_LOG2-1:0] DEN_MAX  = {WIN_LOG2{1'b1}};

  // ---------------------------------------------------------------- synchronizer
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= ota_in;
    end
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_reg[gi] <= 1'b0;
      end else begin
        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------- debouncer
  logic       level_reg;
  logic       level_d_reg;
  logic [3:0] deb_cnt_reg;

  // level flips on the DEB_LEN-th consecutive disagreeing sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      deb_cnt_reg <= 4'd0;
    end else begin
      level_d_reg <= level_reg;
      if (s != level_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          level_reg   <= ~level_reg;
          deb_cnt_reg <= 4'd0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 4'd1;
        end
      end else begin
        deb_cnt_reg <= 4'd0;
      end
    end
  end

  // ---------------------------------------------------------------- window accumulation
  state_t              state_reg;
  logic [WIN_LOG2-1:0] win_cnt_reg;
  logic [WIN_LOG2:0]   ones_reg;
  logic [7:0]          tog_reg;
  logic [WIN_LOG2-1:0] density_reg;
  logic [7:0]          edges_reg;
  logic                valid_reg;
  logic                overrun_reg;

  logic [WIN_LOG2-1:0] win_cnt_next;
  logic [WIN_LOG2:0]   ones_next;
  logic [7:0]          tog_next;
  logic [WIN_LOG2-1:0] density_sat;
  logic                level_chg;
  logic                win_last;
  logic                win_close;

  always_comb begin
    level_chg    = level_reg != level_d_reg;
    win_cnt_next = win_cnt_reg + WIN_ONE;
    ones_next    = ones_reg + {{WIN_LOG2{1'b0}}, s};
    tog_next     = tog_reg;
    if (level_chg && (tog_reg != 8'hFF)) begin
      tog_next = tog_reg + 8'd1;
    end
    // ones can reach exactly 2^WIN_LOG2; only the reported value is clamped
    density_sat = ones_next[WIN_LOG2] ? DEN_MAX : ones_next[WIN_LOG2-1:0];
    win_last    = win_cnt_reg == DEN_MAX;
    win_close   = (state_reg == RUN) && en && win_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      win_cnt_reg <= '0;
      ones_reg    <= '0;
      tog_reg     <= 8'd0;
      density_reg <= '0;
      edges_reg   <= 8'd0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          win_cnt_reg <= '0;
          ones_reg    <= '0;
          tog_reg     <= 8'd0;
          if (en) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!en || win_last) begin
            // partial windows are dropped; completed ones restart with no gap
            win_cnt_reg <= '0;
            ones_reg    <= '0;
            tog_reg     <= 8'd0;
            if (!en) begin
              state_reg <= IDLE;
            end
          end else begin
            win_cnt_reg <= win_cnt_next;
            ones_reg    <= ones_next;
            tog_reg     <= tog_next;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      if (win_close) begin
        density_reg <= density_sat;
        edges_reg   <= tog_next;
        valid_reg   <= 1'b1;
      end else if (valid_reg && density_ready) begin
        valid_reg <= 1'b0;
      end

      // a fresh overrun takes priority over a simultaneous clear
      if (win_close && valid_reg && !density_ready) begin
        overrun_reg <= 1'b1;
      end else if (clr_ovr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign density       = density_reg;
  assign edges         = edges_reg;
  assign density_valid = valid_reg;
  assign level         = level_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_ota_out_decimator.sv
// Self-checking bench for ota_out_decimator: periodic-pattern table through a
// result scoreboard, plus hand sequences for latency, glitch, overrun, abort and reset.
module tb_ota_out_decimator;
  localparam int SYNC = 2;
  localparam int WL   = 4;
  localparam int DEB  = 3;

  logic          clk = 1'b0;
  logic          rst, en, ota_in, density_ready, clr_ovr;
  logic [WL-1:0] density;
  logic [7:0]    edges;
  logic          density_valid, level, overrun;

  ota_out_decimator #(.SYNC_STAGES(SYNC), .WIN_LOG2(WL), .DEB_LEN(DEB)) dut (
    .clk(clk), .rst(rst), .en(en), .ota_in(ota_in),
    .density(density), .edges(edges), .density_valid(density_valid),
    .density_ready(density_ready), .level(level), .overrun(overrun),
    .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {int hi; int lo; int exp_d; int exp_e;} vec_t;
  typedef struct {int d; int e;} res_t;

  vec_t vecs[10];
  res_t sb_q[$];
  int   res_cyc[$];
  int   n_pass = 0, n_checks = 0;
  int   cyc = 0, phase = 0, pat_hi = 0, pat_lo = 16;
  bit   gen_on = 0, mon_on = 0;

  task automatic chk(input string nm, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
  endtask

  // One clock: sample after the edge, then drive the next pattern bit.
  task automatic step();
    res_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_on && density_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", density_valid, 0);
      end else begin
        r = sb_q.pop_front();
        $display("result @%0d: density=%0d edges=%0d (expect %0d/%0d)", cyc, density, edges, r.d, r.e);
        chk("sb_density", density, r.d);
        chk("sb_edges", edges, r.e);
        res_cyc.push_back(cyc);
      end
    end
    if (gen_on) begin
      ota_in = (phase < pat_hi);
      phase  = (phase + 1) % (pat_hi + pat_lo);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int en_cyc, wait_cnt, got_lvl, got_v, d, e, lvl_hi, vseen;
    rst = 1; en = 0; ota_in = 0; density_ready = 1; clr_ovr = 0;
    vecs = '{'{16,0,15,0}, '{0,16,0,0}, '{4,4,8,4}, '{8,8,8,2}, '{2,2,8,0},
             '{1,3,4,0}, '{6,2,12,0}, '{2,6,4,0}, '{3,5,6,4}, '{3,1,12,0}};

    repeat (2) step();
    chk("rst_density", density, 0);
    chk("rst_edges", edges, 0);
    chk("rst_valid", density_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;

    // periodic patterns: three back-to-back windows each
    for (int i = 0; i < 10; i++) begin
      en = 0; mon_on = 0; gen_on = 1;
      pat_hi = vecs[i].hi; pat_lo = vecs[i].lo; phase = 0;
      repeat (24) step();
      sb_q.delete(); res_cyc.delete();
      for (int k = 0; k < 3; k++) sb_q.push_back('{vecs[i].exp_d, vecs[i].exp_e});
      mon_on = 1; en = 1; en_cyc = cyc; wait_cnt = 0;
      while (sb_q.size() > 0 && wait_cnt < 80) begin
        step();
        wait_cnt++;
      end
      chk("vec_pending_results", sb_q.size(), 0);
      if (res_cyc.size() == 3) begin
        chk("vec_first_latency", res_cyc[0] - en_cyc, 17);
        chk("vec_spacing1", res_cyc[1] - res_cyc[0], 16);
        chk("vec_spacing2", res_cyc[2] - res_cyc[1], 16);
      end
      en = 0;
      step();
    end
    gen_on = 0; mon_on = 0;

    // constant high from rest: level latency and first-result latency
    rst = 1; step(); rst = 0;
    density_ready = 0; ota_in = 0; step();
    ota_in = 1; en = 1; got_lvl = -1; got_v = -1; d = -1; e = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (level && got_lvl < 0) got_lvl = k;
      if (density_valid && got_v < 0) begin got_v = k; d = density; e = edges; end
    end
    chk("t1_level_latency", got_lvl, SYNC + 3);
    chk("t1_valid_latency", got_v, 17);
    chk("t1_density", d, 15);
    chk("t1_edges", e, 1);

    // two-cycle glitch is filtered
    en = 0; density_ready = 1; ota_in = 0;
    repeat (30) step();
    en = 1; lvl_hi = 0; got_v = -1;
    for (int k = 1; k <= 20; k++) begin
      ota_in = (k == 6 || k == 7);
      step();
      if (level) lvl_hi = 1;
      if (density_valid && got_v < 0) begin got_v = k; d = density; e = edges; end
    end
    chk("t3_level_high", lvl_hi, 0);
    chk("t3_valid_latency", got_v, 17);
    chk("t3_density", d, 2);
    chk("t3_edges", e, 0);

    // overrun, clear, coincident close+ready, set-wins-over-clear
    en = 0; ota_in = 1;
    repeat (30) step();
    density_ready = 0; en = 1;
    for (int k = 1; k <= 81; k++) begin
      if (k == 18) ota_in = 0;
      if (k == 34 || k == 81) clr_ovr = 1;
      if (k == 49) density_ready = 1;
      if (k == 51) density_ready = 0;
      step();
      clr_ovr = 0;
      case (k)
        17: begin
          chk("t4_w1_valid", density_valid, 1);
          chk("t4_w1_density", density, 15);
          chk("t4_w1_overrun", overrun, 0);
        end
        25: chk("t4_hold_density", density, 15);
        33: begin
          chk("t4_w2_density", density, 2);
          chk("t4_w2_edges", edges, 1);
          chk("t4_w2_overrun", overrun, 1);
        end
        34: chk("t4_clr_overrun", overrun, 0);
        49: begin
          chk("t4_coinc_valid", density_valid, 1);
          chk("t4_coinc_density", density, 0);
          chk("t4_coinc_overrun", overrun, 0);
        end
        50: chk("t4_ready_clears_valid", density_valid, 0);
        81: chk("t4_set_wins", overrun, 1);
        default: ;
      endcase
    end

    // abort a partial window, then restart
    en = 0; density_ready = 1; ota_in = 0;
    repeat (30) step();
    en = 1; ota_in = 1; vseen = 0; got_v = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 11) begin en = 0; ota_in = 0; end
      if (k == 41) en = 1;
      step();
      if (k <= 40 && density_valid) vseen = 1;
      if (k > 40 && density_valid && got_v < 0) begin got_v = k; d = density; e = edges; end
    end
    chk("t5_partial_valid", vseen, 0);
    chk("t5_valid_cycle", got_v, 57);
    chk("t5_density", d, 0);
    chk("t5_edges", e, 0);

    // asynchronous reset while a result is held
    en = 0; ota_in = 1; clr_ovr = 1; step(); clr_ovr = 0;
    repeat (30) step();
    density_ready = 0; en = 1;
    repeat (38) step();
    chk("t6_pre_valid", density_valid, 1);
    chk("t6_pre_overrun", overrun, 1);
    chk("t6_pre_level", level, 1);
    #3 rst = 1;
    #1;
    chk("t6_async_valid", density_valid, 0);
    chk("t6_async_density", density, 0);
    chk("t6_async_edges", edges, 0);
    chk("t6_async_level", level, 0);
    chk("t6_async_overrun", overrun, 0);
    #1 rst = 0;
    got_v = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (density_valid && got_v < 0) begin got_v = k; d = density; e = edges; end
    end
    chk("t6_restart_latency", got_v, 17);
    chk("t6_restart_density", d, 15);
    chk("t6_restart_edges", e, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
